// File: rtl/fifo_rd_stream.sv
// Read-domain drain engine: pops the async FIFO into a head/skid buffer and
// presents the words as a registered valid/ready stream with a delivered-word counter.
module fifo_rd_stream #(
    parameter int D_WIDTH = 8,
    parameter int CNT_W   = 16
) (
    input  logic               rclk,
    input  logic               rrst,
    input  logic               rempty,
    input  logic [D_WIDTH-1:0] rdata,
    output logic               rinc,
    output logic               m_valid,
    output logic [D_WIDTH-1:0] m_data,
    input  logic               m_ready,
    input  logic               flush,
    output logic [1:0]         occ,
    output logic [CNT_W-1:0]   dcount
);

    // Stream handshake: a word moves downstream on every rising rclk edge where
    // m_valid && m_ready; while m_valid=1 and m_ready=0, m_data is held stable and
    // m_valid only drops after a take or a flush.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               push;
    logic               take;
    logic               load_head_rdata;
    logic               load_head_skid;
    logic               load_skid;
    logic [D_WIDTH-1:0] skid;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) state <= EMPTY;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        load_head_rdata = 1'b0;
        load_head_skid  = 1'b0;
        load_skid       = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt       = HALF;
                    load_head_rdata = 1'b1;
                end
            end
            HALF: begin
                if (push && take) begin
                    load_head_rdata = 1'b1;
                end else if (push) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (take) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // Pop is blocked in FULL, so only a take can move us.
                if (take) begin
                    state_nxt      = HALF;
                    load_head_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt       = EMPTY;
            load_head_rdata = 1'b0;
            load_head_skid  = 1'b0;
            load_skid       = 1'b0;
        end
    end

    // rinc deliberately ignores m_ready so the pop path stays short.
    always_comb begin
        rinc = !rempty && (state != FULL) && !flush && !rrst;
        push = rinc;
        take = m_valid && m_ready;
        occ  = state;
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            skid    <= '0;
        end else begin
            m_valid <= (state_nxt != EMPTY);
            if (load_head_rdata)     m_data <= rdata;
            else if (load_head_skid) m_data <= skid;
            if (load_skid)           skid   <= rdata;
        end
    end

    // Takes in a flush cycle still count; flush never clears the counter.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst)      dcount <= '0;
        else if (take) dcount <= dcount + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a queue models the FIFO read side and a
// scoreboard queue holds the words expected downstream in order.
module tb_fifo_rd_stream;

    logic        rclk;
    logic        rrst;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic        flush;
    logic [1:0]  occ;
    logic [15:0] dcount;

    logic        rinc4;
    logic        m_valid4;
    logic [7:0]  m_data4;
    logic [1:0]  occ4;
    logic [3:0]  dcount4;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int total;
    int bad;

    fifo_rd_stream #(.D_WIDTH(8), .CNT_W(16)) dut (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .flush(flush),
        .occ(occ), .dcount(dcount)
    );

    fifo_rd_stream #(.D_WIDTH(8), .CNT_W(4)) dut4 (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc4),
        .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready), .flush(flush),
        .occ(occ4), .dcount(dcount4)
    );

    // clock / reset
    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
        rempty = 1'b0;
        rdata  = fifo_q[0];
    endtask

    // One rclk cycle: sample at negedge, score takes, advance FIFO model after the edge.
    task automatic step();
        logic pop;
        logic tk;
        @(negedge rclk);
        pop = rinc;
        tk  = m_valid && m_ready;
        check_val("occ_max", 32'(occ > 2'd2), 32'd0);
        if (tk) begin
            if (exp_q.size() == 0) check_val("sb_extra", 32'd1, 32'd0);
            else                   check_val("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
        @(posedge rclk);
        #1;
        if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        rempty = (fifo_q.size() == 0);
        rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rrst    = 1'b1;
        rempty  = 1'b1;
        rdata   = 8'h00;
        m_ready = 1'b1;
        flush   = 1'b0;

        // reset values, with words already waiting in the FIFO
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        #1;
        check_val("rst_occ", 32'(occ), 32'd0);
        check_val("rst_valid", 32'(m_valid), 32'd0);
        check_val("rst_data", 32'(m_data), 32'd0);
        check_val("rst_dcount", 32'(dcount), 32'd0);
        check_val("rst_rinc", 32'(rinc), 32'd0);
        @(posedge rclk);
        #1;
        rrst = 1'b0;
        #1;

        // three-word stream at full rate
        check_val("t1_rinc0", 32'(rinc), 32'd1);
        step();
        check_val("t1_valid1", 32'(m_valid), 32'd1);
        check_val("t1_data1", 32'(m_data), 32'h11);
        check_val("t1_rinc1", 32'(rinc), 32'd1);
        step();
        check_val("t1_data2", 32'(m_data), 32'h22);
        check_val("t1_rinc2", 32'(rinc), 32'd1);
        step();
        check_val("t1_data3", 32'(m_data), 32'h33);
        check_val("t1_rinc3", 32'(rinc), 32'd0);
        step();
        check_val("t1_valid_end", 32'(m_valid), 32'd0);
        check_val("t1_dcount", 32'(dcount), 32'd3);

        // backpressure fills the buffer, then drains without gaps
        m_ready = 1'b0;
        push_word(8'h41);
        push_word(8'h42);
        push_word(8'h43);
        push_word(8'h44);
        #1;
        step();
        step();
        check_val("t2_occ_full", 32'(occ), 32'd2);
        check_val("t2_rinc_full", 32'(rinc), 32'd0);
        check_val("t2_valid", 32'(m_valid), 32'd1);
        check_val("t2_data_a", 32'(m_data), 32'h41);
        step();
        check_val("t2_data_hold", 32'(m_data), 32'h41);
        check_val("t2_occ_hold", 32'(occ), 32'd2);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("t2_no_gap", 32'(m_valid), 32'd1);
            step();
        end
        check_val("t2_valid_end", 32'(m_valid), 32'd0);
        check_val("t2_occ_end", 32'(occ), 32'd0);
        check_val("t2_dcount", 32'(dcount), 32'd7);

        // 100 words with random backpressure
        for (int i = 0; i < 100; i++) push_word(8'($urandom_range(0, 255)));
        #1;
        for (int c = 0; c < 2000 && exp_q.size() != 0; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            step();
        end
        check_val("t3_drained", 32'(exp_q.size()), 32'd0);
        check_val("t3_dcount", 32'(dcount), 32'd107);
        m_ready = 1'b1;
        step();
        check_val("t3_occ_end", 32'(occ), 32'd0);

        // flush a full buffer under backpressure
        m_ready = 1'b0;
        push_word(8'hA5);
        push_word(8'h5A);
        push_word(8'h77);
        #1;
        step();
        step();
        check_val("t4_occ_full", 32'(occ), 32'd2);
        check_val("t4_head", 32'(m_data), 32'hA5);
        flush = 1'b1;
        #1;
        check_val("t4_rinc_flush", 32'(rinc), 32'd0);
        step();
        flush = 1'b0;
        check_val("t4_occ", 32'(occ), 32'd0);
        check_val("t4_valid", 32'(m_valid), 32'd0);
        check_val("t4_dcount", 32'(dcount), 32'd107);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        m_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        check_val("t4_next_word", 32'(exp_q.size()), 32'd0);
        check_val("t4_dcount_after", 32'(dcount), 32'd108);

        // asynchronous reset with a full buffer
        m_ready = 1'b0;
        push_word(8'h01);
        push_word(8'h02);
        push_word(8'h03);
        #1;
        step();
        step();
        check_val("t5_occ_full", 32'(occ), 32'd2);
        #1;
        rrst = 1'b1;
        #1;
        check_val("t5_valid", 32'(m_valid), 32'd0);
        check_val("t5_occ", 32'(occ), 32'd0);
        check_val("t5_dcount", 32'(dcount), 32'd0);
        check_val("t5_rinc", 32'(rinc), 32'd0);
        fifo_q.delete();
        exp_q.delete();
        rempty = 1'b1;
        rdata  = 8'h00;
        @(posedge rclk);
        #1;
        rrst = 1'b0;
        #1;

        // 17 words: the 4-bit counter wraps to 1
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) push_word(8'(i * 3 + 7));
        #1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) step();
        check_val("t6_drained", 32'(exp_q.size()), 32'd0);
        check_val("t6_dcount16", 32'(dcount), 32'd17);
        check_val("t6_dcount4", 32'(dcount4), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
